ppt_spi_regs: RTL and testbench

SPI-slave configuration and status register block that sits directly upstream of the thruster pulse generator. It drives the pulse generator's run, pulse_period and pulse_width inputs, and watches the generated pulse_out (returned here as pulse_in). It counts delivered shots and auto-stops after a programmable shot limit. All logic runs in the clk domain; the SPI pins are oversampled.

---
 rtl/ppt_regs_pkg.sv | 25 ++
 rtl/spi_frame_rx.sv | 106 ++++++++++
 rtl/ppt_spi_regs.sv | 94 +++++++++
 tb/tb_ppt_spi_regs.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppt_regs_pkg.sv
// rtl/ppt_regs_pkg.sv - shared constants and types for the thruster SPI register block
package ppt_regs_pkg;

    localparam int FRAME_BITS = 24;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 16;

    localparam logic [ADDR_BITS-1:0] ADDR_CTRL   = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_PERIOD = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_WIDTH  = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_SHOTS  = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_COUNT  = 7'h04;
    localparam logic [ADDR_BITS-1:0] ADDR_STATUS = 7'h05;
    localparam logic [ADDR_BITS-1:0] ADDR_ID     = 7'h07;

    localparam logic [14:0] PERIOD_RST = 15'd128;
    localparam logic [14:0] WIDTH_RST  = 15'd1;

    typedef struct packed {
        logic cfg_err;
        logic done;
        logic run;
    } status_t;

endpackage

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled mode-0 SPI slave framing: 24-bit frames, write/read strobes, MISO shifting
module spi_frame_rx
    import ppt_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 wr_strobe,
    output logic                 rd_strobe,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] wdata,
    input  logic [DATA_BITS-1:0] rdata
);

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic                   frame_open, take, addr_done, last_bit, rw;
    logic [4:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift, tx_shift;
    logic                   tx_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    // frame_open closes after the 24th bit so trailing sck edges are ignored
    assign take      = frame_open & ~cs_s & sck_rise;
    assign addr_done = take && (bit_cnt == 5'(ADDR_BITS));
    assign last_bit  = take && (bit_cnt == 5'(FRAME_BITS - 1));
    assign wdata     = shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            frame_open <= 1'b0;
            shift      <= '0;
            rw         <= 1'b0;
            addr       <= '0;
            wr_strobe  <= 1'b0;
            rd_strobe  <= 1'b0;
        end else begin
            wr_strobe <= last_bit & ~rw;
            rd_strobe <= addr_done & shift[ADDR_BITS-1];
            if (cs_fall) begin
                bit_cnt    <= '0;
                frame_open <= 1'b1;
            end else if (cs_rise || last_bit) begin
                frame_open <= 1'b0;
            end
            if (take) begin
                bit_cnt <= bit_cnt + 5'd1;
                shift   <= {shift[DATA_BITS-2:0], mosi_s};
            end
            if (addr_done) begin
                rw   <= shift[ADDR_BITS-1];
                addr <= {shift[ADDR_BITS-2:0], mosi_s};
            end
        end
    end

    // read data is loaded one clk after the address byte; the first sck fall is at least two clk later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= '0;
            tx_active <= 1'b0;
            spi_miso  <= 1'b0;
        end else if (cs_fall || cs_rise || last_bit) begin
            tx_active <= 1'b0;
            spi_miso  <= 1'b0;
        end else if (rd_strobe) begin
            tx_shift  <= rdata;
            tx_active <= 1'b1;
        end else if (tx_active && sck_fall) begin
            spi_miso <= tx_shift[DATA_BITS-1];
            tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ppt_spi_regs.sv
// rtl/ppt_spi_regs.sv - SPI register file driving the thruster pulse generator, with shot counting and auto-stop
module ppt_spi_regs
    import ppt_regs_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        pulse_in,
    output logic        run,
    output logic [14:0] pulse_period,
    output logic [14:0] pulse_width
);

    logic                 wr_strobe, rd_strobe;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata, rdata, rd_word;
    logic [DATA_BITS-1:0] shots, count, count_next;
    logic                 done, pulse_d;
    logic                 cfg_err, ctrl_wr, run_set, shot, limit_hit;
    status_t              status;

    spi_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata)
    );

    assign cfg_err    = (pulse_width == '0) || (pulse_width >= pulse_period);
    assign ctrl_wr    = wr_strobe && (addr == ADDR_CTRL);
    assign run_set    = ctrl_wr && wdata[0] && !cfg_err;
    assign shot       = pulse_in && !pulse_d && run;
    assign count_next = (count == '1) ? count : count + 16'd1;
    assign limit_hit  = shot && (shots != '0) && (count_next == shots);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run          <= 1'b0;
            done         <= 1'b0;
            pulse_period <= PERIOD_RST;
            pulse_width  <= WIDTH_RST;
            shots        <= '0;
            count        <= '0;
            pulse_d      <= 1'b0;
        end else begin
            pulse_d <= pulse_in;
            if (wr_strobe && addr == ADDR_PERIOD) pulse_period <= wdata[14:0];
            if (wr_strobe && addr == ADDR_WIDTH)  pulse_width  <= wdata[14:0];
            if (wr_strobe && addr == ADDR_SHOTS)  shots        <= wdata;
            if (ctrl_wr && wdata[1])  count <= '0;
            else if (shot)            count <= count_next;
            // a CTRL write that actually takes effect overrides the shot-limit stop
            if (ctrl_wr && (!wdata[0] || !cfg_err)) run <= wdata[0];
            else if (limit_hit)                     run <= 1'b0;
            if (run_set)        done <= 1'b0;
            else if (limit_hit) done <= 1'b1;
        end
    end

    always_comb begin
        status.cfg_err = cfg_err;
        status.done    = done;
        status.run     = run;
        rd_word        = '0;
        case (addr)
            ADDR_CTRL:   rd_word = {15'b0, run};
            ADDR_PERIOD: rd_word = {1'b0, pulse_period};
            ADDR_WIDTH:  rd_word = {1'b0, pulse_width};
            ADDR_SHOTS:  rd_word = shots;
            ADDR_COUNT:  rd_word = count;
            ADDR_STATUS: rd_word = {13'b0, status};
            ADDR_ID:     rd_word = {8'h00, ID_VALUE};
            default:     rd_word = '0;
        endcase
    end

    assign rdata = rd_strobe ? rd_word : '0;

endmodule

// File: tb/tb_ppt_spi_regs.sv
// tb/tb_ppt_spi_regs.sv - self-checking bench for ppt_spi_regs against a register-level reference model
module tb_ppt_spi_regs;
    import ppt_regs_pkg::*;

    localparam int CLK_NS = 10;
    localparam int HALF   = 30;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst_n, spi_sck, spi_cs_n, spi_mosi, spi_miso, pulse_in, run;
    logic [14:0] pulse_period, pulse_width;
    int          n_checks = 0;
    int          n_fail = 0;

    always #(CLK_NS / 2) clk = ~clk;

    ppt_spi_regs #(.ID_VALUE(8'hA5), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sck      (spi_sck),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .pulse_in     (pulse_in),
        .run          (run),
        .pulse_period (pulse_period),
        .pulse_width  (pulse_width)
    );

    // pulse generator stand-in: high for width clk at the start of every period while run
    logic gen_en;
    int   gcnt;
    always @(posedge clk) begin
        if (!run || !gen_en) begin
            gcnt     <= 0;
            pulse_in <= 1'b0;
        end else begin
            pulse_in <= (gcnt < int'(pulse_width));
            gcnt     <= (gcnt + 1 >= int'(pulse_period)) ? 0 : gcnt + 1;
        end
    end

    int  rises = 0;
    time t_pulse, t_run_rise, t_run_fall, t_last_rise;
    always @(posedge pulse_in) begin rises++; t_pulse = $time; end
    always @(posedge run) t_run_rise = $time;
    always @(negedge run) t_run_fall = $time;

    // reference model of the register map
    logic        m_run, m_done;
    logic [14:0] m_period, m_width;
    logic [15:0] m_shots, m_count;

    function automatic logic m_cfg_err();
        return (m_width == 0) || (m_width >= m_period);
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_period = 128; m_width = 1; m_shots = 0; m_count = 0;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [15:0] d);
        case (a)
            7'h00: begin
                if (d[0] && !m_cfg_err()) begin m_run = 1; m_done = 0; end
                else if (!d[0]) m_run = 0;
                if (d[1]) m_count = 0;
            end
            7'h01: m_period = d[14:0];
            7'h02: m_width = d[14:0];
            7'h03: m_shots = d;
            default: ;
        endcase
    endtask

    function automatic logic [15:0] model_read(input logic [6:0] a);
        case (a)
            7'h00: return {15'b0, m_run};
            7'h01: return {1'b0, m_period};
            7'h02: return {1'b0, m_width};
            7'h03: return m_shots;
            7'h04: return m_count;
            7'h05: return {13'b0, m_cfg_err(), m_done, m_run};
            7'h07: return 16'h00A5;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_frame(input logic rw, input logic [6:0] a, input logic [15:0] d,
                             input int nbits, input bit hold_cs, output logic [15:0] rd);
        logic [23:0] f;
        f  = {rw, a, d};
        rd = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = f[23-i];
            #HALF;
            if (i >= 8) rd[23-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 23) t_last_rise = $time;
            #HALF;
            spi_sck = 1'b0;
        end
        if (!hold_cs) begin
            #HALF;
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            #(4 * HALF);
        end
    endtask

    task automatic reg_write(input logic [6:0] a, input logic [15:0] d);
        logic [15:0] rd;
        spi_frame(1'b0, a, d, 24, 1'b0, rd);
        model_write(a, d);
    endtask

    task automatic reg_read(input logic [6:0] a, output logic [15:0] rd);
        spi_frame(1'b1, a, 16'h0000, 24, 1'b0, rd);
    endtask

    task automatic reg_read_chk(input string tag, input logic [6:0] a);
        logic [15:0] rd;
        reg_read(a, rd);
        chk(tag, rd, model_read(a));
    endtask

    initial begin
        #2ms;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [6:0]  a;
        logic [15:0] d;
        int          base, w;

        spi_sck = 0; spi_cs_n = 1; spi_mosi = 0; gen_en = 0; rst_n = 1;
        #1 rst_n = 0;
        model_reset();
        #30;
        @(negedge clk) rst_n = 1;
        repeat (2) @(negedge clk);
        chk("rst_run", run, 0);
        chk("rst_period", pulse_period, 128);
        chk("rst_width", pulse_width, 1);
        chk("rst_miso", spi_miso, 0);

        reg_read(ADDR_ID, rd);
        chk("rd_id", rd, 16'h00A5);
        reg_read(ADDR_PERIOD, rd);
        chk("rd_period_rst", rd, 16'd128);

        reg_write(ADDR_PERIOD, 16'd10);
        reg_write(ADDR_WIDTH, 16'd3);
        reg_write(ADDR_CTRL, 16'd1);
        chk("cfg_period", pulse_period, 10);
        chk("cfg_width", pulse_width, 3);
        chk("cfg_run", run, 1);
        chk("run_latency", (t_run_rise > t_last_rise) &&
            (t_run_rise - t_last_rise <= (SYNC + 3) * CLK_NS), 1);

        reg_write(ADDR_CTRL, 16'd0);
        reg_write(ADDR_WIDTH, 16'd10);
        reg_write(ADDR_CTRL, 16'd1);
        chk("cfgerr_run", run, 0);
        reg_read(ADDR_STATUS, rd);
        chk("cfgerr_status", rd, 16'h0004);

        reg_write(ADDR_WIDTH, 16'd3);
        reg_write(ADDR_SHOTS, 16'd5);
        reg_write(ADDR_CTRL, 16'd2);
        gen_en = 1;
        base = rises;
        reg_write(ADDR_CTRL, 16'd1);
        w = 0;
        while (run !== 1'b0 && w < 1000) begin @(negedge clk); w++; end
        chk("shots_timeout", w < 1000, 1);
        repeat (30) @(negedge clk);
        chk("shot_rises", rises - base, 5);
        chk("stop_latency", 32'(t_run_fall - t_pulse), CLK_NS);
        gen_en = 0;
        m_run = 0; m_done = 1; m_count = m_shots;
        reg_read(ADDR_STATUS, rd);
        chk("shots_status", rd, 16'h0002);
        reg_read(ADDR_COUNT, rd);
        chk("shots_count", rd, 16'd5);

        spi_frame(1'b0, ADDR_PERIOD, 16'h0033, 12, 1'b0, rd);
        chk("abort_period", pulse_period, m_period);
        reg_read_chk("abort_rd_period", ADDR_PERIOD);
        reg_write(ADDR_PERIOD, 16'h0020);
        chk("post_abort_period", pulse_period, 16'h0020);
        reg_read_chk("post_abort_rd", ADDR_PERIOD);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
            d = (a == ADDR_PERIOD || a == ADDR_WIDTH) ? 16'($urandom_range(0, 24)) : 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                reg_write(a, d);
                chk("rnd_run", run, m_run);
                chk("rnd_period", pulse_period, m_period);
                chk("rnd_width", pulse_width, m_width);
            end else begin
                reg_read_chk("rnd_read", a);
            end
        end

        reg_write(ADDR_SHOTS, 16'hFFFF);
        reg_write(ADDR_PERIOD, 16'd50);
        reg_write(ADDR_WIDTH, 16'd5);
        reg_write(ADDR_CTRL, 16'd1);
        chk("pre_rst_run", run, 1);
        spi_frame(1'b1, ADDR_SHOTS, 16'h0000, 12, 1'b1, rd);
        #43;
        chk("mid_read_miso", spi_miso, 1);
        rst_n = 0;
        #1;
        chk("arst_run", run, 0);
        chk("arst_period", pulse_period, 128);
        chk("arst_width", pulse_width, 1);
        chk("arst_miso", spi_miso, 0);
        model_reset();
        spi_cs_n = 1;
        spi_mosi = 0;
        #50;
        @(negedge clk) rst_n = 1;
        repeat (3) @(negedge clk);
        reg_write(ADDR_WIDTH, 16'd5);
        chk("post_rst_width", pulse_width, 5);
        reg_read_chk("post_rst_rd_width", ADDR_WIDTH);
        reg_read_chk("post_rst_rd_shots", ADDR_SHOTS);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
